// File: rtl/blink_pkg.sv
// Shared constants for the LED pattern driver and its button reader front end.
package blink_pkg;

    localparam int unsigned DEF_N_BTN        = 4;
    localparam int unsigned SEL_W            = 2;
    localparam int unsigned DEF_DEBOUNCE_CYC = 1_000_000;   // 20 ms @ 50 MHz
    localparam int unsigned DEF_LONG_CYC     = 50_000_000;  // 1 s @ 50 MHz
    localparam int unsigned SIM_DEBOUNCE_CYC = 4;
    localparam int unsigned SIM_LONG_CYC     = 16;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchroniser, debounce filter, press/release edge pulses
// and a saturating hold counter that fires a single long-press pulse.
module btn_debounce
    import blink_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = DEF_LONG_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_press_c
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);

    logic              r_meta;
    logic              r_sync;
    logic              r_stable;
    logic [DB_W-1:0]   r_db_cnt;
    logic [HOLD_W-1:0] r_hold;
    logic              r_press;
    logic              r_release;
    logic              r_long;

    logic w_differ;
    logic w_toggle;
    logic w_long_hit;

    assign w_differ   = (r_sync != r_stable);
    assign w_toggle   = w_differ && (r_db_cnt == DB_W'(DEBOUNCE_CYC - 1));
    assign w_long_hit = r_stable && (r_hold == HOLD_W'(LONG_CYC - 1));

    // Synchroniser and debounce filter; any return to the stable level restarts the count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta    <= 1'b0;
            r_sync    <= 1'b0;
            r_stable  <= 1'b0;
            r_db_cnt  <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_meta    <= i_btn;
            r_sync    <= r_meta;
            r_stable  <= r_stable ^ w_toggle;
            r_press   <= w_toggle & ~r_stable;
            r_release <= w_toggle & r_stable;
            if (!w_differ || w_toggle) begin
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // Hold counter saturates at LONG_CYC so the long pulse fires once per press
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= w_long_hit;
            if (!r_stable) begin
                r_hold <= '0;
            end else if (r_hold != HOLD_W'(LONG_CYC)) begin
                r_hold <= r_hold + HOLD_W'(1);
            end
        end
    end

    assign o_level   = r_stable;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
    assign o_press_c = w_toggle & ~r_stable;

endmodule

// File: rtl/button_reader.sv
// Debounced pushbutton reader: per-channel events plus a 2-bit index of the
// most recently pressed button, aligned with its press pulse.
module button_reader
    import blink_pkg::*;
#(
    parameter int unsigned N_BTN          = DEF_N_BTN,
    parameter int unsigned DEBOUNCE_CYC   = DEF_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC       = DEF_LONG_CYC,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output sel_t             sel,
    output logic             sel_valid
);

    logic [N_BTN-1:0] w_btn;
    logic [N_BTN-1:0] w_press_c;
    sel_t             w_sel_c;
    sel_t             r_sel;
    logic             r_sel_valid;

    assign w_btn = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC)
        ) u_btn (
            .clk       (clk),
            .reset     (reset),
            .i_btn     (w_btn[g]),
            .o_level   (btn_level[g]),
            .o_press   (press_pulse[g]),
            .o_release (release_pulse[g]),
            .o_long    (long_pulse[g]),
            .o_press_c (w_press_c[g])
        );
    end

    // Priority encoder on the upcoming press pulses, lowest index wins
    always_comb begin
        w_sel_c = r_sel;
        for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
            if (w_press_c[i]) begin
                w_sel_c = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel       <= '0;
            r_sel_valid <= 1'b0;
        end else begin
            r_sel       <= w_sel_c;
            r_sel_valid <= |w_press_c;
        end
    end

    assign sel       = r_sel;
    assign sel_valid = r_sel_valid;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with short debounce/long-press timings.
module tb_button_reader;
    import blink_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] long_pulse;
    sel_t       sel;
    logic       sel_valid;

    int n_assert = 0;
    int n_fail   = 0;

    button_reader #(
        .N_BTN          (4),
        .DEBOUNCE_CYC   (SIM_DEBOUNCE_CYC),
        .LONG_CYC       (SIM_LONG_CYC),
        .BTN_ACTIVE_LOW (1'b0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .sel           (sel),
        .sel_valid     (sel_valid)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b0;
        btn_raw = 4'b0000;
        step(3);
        chk("rst_level", 32'(btn_level), 0);
        chk("rst_press", 32'(press_pulse), 0);
        chk("rst_release", 32'(release_pulse), 0);
        chk("rst_long", 32'(long_pulse), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_sel_valid", 32'(sel_valid), 0);
        reset = 1'b1;
        step(3);
        chk("rst_exit_press", 32'(press_pulse), 0);

        // Clean press and release on button 0
        btn_raw = 4'b0001;
        step(5);
        chk("t1_level_early", 32'(btn_level), 0);
        chk("t1_press_early", 32'(press_pulse), 0);
        step(1);
        chk("t1_level", 32'(btn_level), 32'h1);
        chk("t1_press", 32'(press_pulse), 32'h1);
        chk("t1_sel", 32'(sel), 0);
        chk("t1_sel_valid", 32'(sel_valid), 1);
        step(1);
        chk("t1_press_once", 32'(press_pulse), 0);
        chk("t1_sel_valid_once", 32'(sel_valid), 0);
        btn_raw = 4'b0000;
        step(5);
        chk("t1_release_early", 32'(release_pulse), 0);
        step(1);
        chk("t1_release", 32'(release_pulse), 32'h1);
        chk("t1_level_low", 32'(btn_level), 0);
        step(1);
        chk("t1_release_once", 32'(release_pulse), 0);
        chk("t1_no_long", 32'(long_pulse), 0);

        // Bouncing button 2, then held high
        for (int k = 0; k < 6; k++) begin
            btn_raw = (k % 2 == 0) ? 4'b0100 : 4'b0000;
            for (int c = 0; c < 2; c++) begin
                step(1);
                chk("t2_bounce_press", 32'(press_pulse), 0);
                chk("t2_bounce_level", 32'(btn_level), 0);
            end
        end
        btn_raw = 4'b0100;
        step(5);
        chk("t2_press_early", 32'(press_pulse), 0);
        step(1);
        chk("t2_press", 32'(press_pulse), 32'h4);
        chk("t2_sel", 32'(sel), 2);
        chk("t2_sel_valid", 32'(sel_valid), 1);
        step(1);
        chk("t2_press_once", 32'(press_pulse), 0);
        btn_raw = 4'b0000;
        step(6);
        chk("t2_release", 32'(release_pulse), 32'h4);
        step(2);

        // Three-cycle glitch on button 1 must be filtered
        btn_raw = 4'b0010;
        step(3);
        btn_raw = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            step(1);
            chk("t3_level", 32'(btn_level), 0);
            chk("t3_press", 32'(press_pulse), 0);
            chk("t3_release", 32'(release_pulse), 0);
        end

        // Long press on button 3, once only, then a short hold with no long pulse
        btn_raw = 4'b1000;
        step(6);
        chk("t4_press", 32'(press_pulse), 32'h8);
        chk("t4_sel", 32'(sel), 3);
        step(15);
        chk("t4_long_early", 32'(long_pulse), 0);
        step(1);
        chk("t4_long", 32'(long_pulse), 32'h8);
        for (int c = 0; c < 24; c++) begin
            step(1);
            chk("t4_long_repeat", 32'(long_pulse), 0);
        end
        btn_raw = 4'b0000;
        step(6);
        chk("t4_release", 32'(release_pulse), 32'h8);
        step(2);
        btn_raw = 4'b1000;
        step(6);
        chk("t4_short_press", 32'(press_pulse), 32'h8);
        step(2);
        btn_raw = 4'b0000;
        for (int c = 0; c < 20; c++) begin
            step(1);
            chk("t4_short_no_long", 32'(long_pulse), 0);
        end

        // Simultaneous presses on buttons 1 and 3
        btn_raw = 4'b1010;
        step(5);
        chk("t5_press_early", 32'(press_pulse), 0);
        step(1);
        chk("t5_press", 32'(press_pulse), 32'ha);
        chk("t5_sel", 32'(sel), 1);
        chk("t5_sel_valid", 32'(sel_valid), 1);
        step(1);
        chk("t5_sel_valid_once", 32'(sel_valid), 0);
        chk("t5_sel_hold", 32'(sel), 1);
        btn_raw = 4'b0000;
        step(6);
        chk("t5_release", 32'(release_pulse), 32'ha);
        step(2);

        // Reset in the middle of a hold, button kept down through reset exit
        btn_raw = 4'b0001;
        step(6);
        chk("t6_press", 32'(press_pulse), 32'h1);
        chk("t6_sel", 32'(sel), 0);
        step(10);
        chk("t6_level_pre", 32'(btn_level), 32'h1);
        reset = 1'b0;
        #1;
        chk("t6_async_level", 32'(btn_level), 0);
        chk("t6_async_long", 32'(long_pulse), 0);
        chk("t6_async_sel_valid", 32'(sel_valid), 0);
        step(2);
        reset = 1'b1;
        step(5);
        chk("t6_press_early", 32'(press_pulse), 0);
        step(1);
        chk("t6_repress", 32'(press_pulse), 32'h1);
        chk("t6_relevel", 32'(btn_level), 32'h1);
        step(15);
        chk("t6_long_early", 32'(long_pulse), 0);
        step(1);
        chk("t6_long", 32'(long_pulse), 32'h1);
        btn_raw = 4'b0000;
        step(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
